// File: rtl/arbitro_rodizio.sv
// Round-robin arbiter for one 8-way resource: registered one-hot grant plus
// binary index, with an optional hold limit that forces the owner to release.
module arbitro_rodizio #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N     = 8;
  localparam int unsigned IW    = 3;
  localparam int unsigned CW    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned LIMIT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {
    OCIOSO,
    CONCEDIDO
  } estado_t;

  estado_t        estado, estado_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [IW-1:0]  owner, owner_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [N-1:0]   gnt_n;
  logic [IW-1:0]  gnt_idx_n;
  logic           gnt_valid_n;
  logic           timeout_n;
  logic [IW:0]    win;
  logic           grant_new;

  // First set request found scanning upward from base (mod 8); MSB = found.
  function automatic logic [IW:0] arbitra(input logic [N-1:0] r, input logic [IW-1:0] base);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = base + IW'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      estado    <= estado_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
    end
  end

  // ptr always sits one past the owner, so a scan from ptr visits the owner last.
  always_comb begin
    estado_n    = estado;
    ptr_n       = ptr;
    owner_n     = owner;
    cnt_n       = cnt;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;
    grant_new   = 1'b0;
    win         = arbitra(req, ptr);

    case (estado)
      OCIOSO: begin
        if (win[IW]) grant_new = 1'b1;
      end
      CONCEDIDO: begin
        if (!req[owner]) begin
          if (win[IW]) begin
            grant_new = 1'b1;
          end else begin
            estado_n    = OCIOSO;
            cnt_n       = '0;
            gnt_n       = '0;
            gnt_idx_n   = '0;
            gnt_valid_n = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (cnt == CW'(LIMIT))) begin
          timeout_n = 1'b1;
          grant_new = 1'b1;
        end else if (cnt != CW'(LIMIT)) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: estado_n = OCIOSO;
    endcase

    if (grant_new) begin
      estado_n    = CONCEDIDO;
      owner_n     = win[IW-1:0];
      ptr_n       = win[IW-1:0] + IW'(1);
      cnt_n       = '0;
      gnt_n       = N'(1) << win[IW-1:0];
      gnt_idx_n   = win[IW-1:0];
      gnt_valid_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_arbitro_rodizio.sv
// Directed bench for arbitro_rodizio: vector table on the default-limit
// instance plus hand sequences for reset, rotation and hold-limit behaviour.
module tb_arbitro_rodizio;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req16, req4, req0;
  logic [7:0] gnt16, gnt4, gnt0;
  logic [2:0] idx16, idx4, idx0;
  logic       val16, val4, val0;
  logic       to16, to4, to0;

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_rodizio #(.MAX_HOLD(16)) dut16 (
    .clk(clk), .reset(reset), .req(req16),
    .gnt(gnt16), .gnt_idx(idx16), .gnt_valid(val16), .timeout(to16));

  arbitro_rodizio #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .timeout(to4));

  arbitro_rodizio #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .timeout(to0));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t tab[13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic t,
                         input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev, input logic et);
    chk({nm, ".gnt"}, g, eg);
    chk({nm, ".idx"}, 8'(i), 8'(ei));
    chk({nm, ".valid"}, 8'(v), 8'(ev));
    chk({nm, ".timeout"}, 8'(t), 8'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] eg;
    logic       et;

    // single requester, wrap-around, no preemption, ptr-ordered search
    tab[0]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tab[1]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tab[2]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    tab[3]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tab[4]  = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tab[5]  = '{8'h83, 8'h80, 3'd7, 1'b1, 1'b0};
    tab[6]  = '{8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
    tab[7]  = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
    tab[8]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tab[9]  = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
    tab[10] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tab[11] = '{8'hFF, 8'h01, 3'd0, 1'b1, 1'b0};
    tab[12] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    reset = 1'b1;
    req16 = '0;
    req4  = '0;
    req0  = '0;
    tick();
    tick();
    chk_all("reset16", gnt16, idx16, val16, to16, 8'h00, 3'd0, 1'b0, 1'b0);
    chk_all("reset4", gnt4, idx4, val4, to4, 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (tab[i]) begin
      req16 = tab[i].req;
      tick();
      chk_all($sformatf("vec%0d", i), gnt16, idx16, val16, to16,
              tab[i].gnt, tab[i].idx, tab[i].valid, tab[i].to);
    end

    // asynchronous reset mid-grant, then first arbitration starts at 0
    req16 = 8'h10;
    tick();
    chk_all("pre_reset", gnt16, idx16, val16, to16, 8'h10, 3'd4, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk_all("async_reset", gnt16, idx16, val16, to16, 8'h00, 3'd0, 1'b0, 1'b0);
    req16 = 8'h81;
    #2 reset = 1'b0;
    tick();
    chk_all("post_reset", gnt16, idx16, val16, to16, 8'h01, 3'd0, 1'b1, 1'b0);
    req16 = '0;
    tick();
    chk("post_reset_idle", gnt16, 8'h00);

    // rotation: every owner drops its request for one cycle after two grant cycles
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    req16 = 8'hFF;
    tick();
    chk("rot_first", gnt16, 8'h01);
    for (int k = 0; k < 8; k++) begin
      req16 = 8'hFF;
      tick();
      chk($sformatf("rot_hold%0d", k), gnt16, 8'h01 << k);
      req16 = 8'hFF & ~(8'h01 << k);
      tick();
      chk_all($sformatf("rot_next%0d", k), gnt16, idx16, val16, to16,
              8'h01 << ((k + 1) % 8), 3'((k + 1) % 8), 1'b1, 1'b0);
    end
    req16 = '0;
    tick();
    chk("rot_idle", gnt16, 8'h00);

    // forced release alternates between two constant requesters
    req4 = 8'h05;
    for (int n = 1; n <= 16; n++) begin
      tick();
      eg = (((n - 1) / 4) % 2 == 0) ? 8'h01 : 8'h04;
      et = (n > 1) && ((n - 1) % 4 == 0);
      chk_all($sformatf("forced%0d", n), gnt4, idx4, val4, to4,
              eg, (eg == 8'h01) ? 3'd0 : 3'd2, 1'b1, et);
    end
    req4 = '0;
    tick();
    chk("forced_idle", gnt4, 8'h00);

    // sole requester: re-granted with no gap; unlimited mode never times out
    req4 = 8'h40;
    req0 = 8'h40;
    for (int n = 1; n <= 13; n++) begin
      tick();
      et = (n > 1) && ((n - 1) % 4 == 0);
      chk_all($sformatf("sole4_%0d", n), gnt4, idx4, val4, to4, 8'h40, 3'd6, 1'b1, et);
      chk_all($sformatf("sole0_%0d", n), gnt0, idx0, val0, to0, 8'h40, 3'd6, 1'b1, 1'b0);
    end
    req4 = '0;
    req0 = '0;
    tick();
    chk("sole_idle", gnt4, 8'h00);

    // owner drop coinciding with the hold limit is a normal release
    req4 = 8'h01;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk($sformatf("limit_hold%0d", n), gnt4, 8'h01);
    end
    req4 = 8'h02;
    tick();
    chk_all("limit_drop", gnt4, idx4, val4, to4, 8'h02, 3'd1, 1'b1, 1'b0);
    req4 = '0;
    tick();
    chk("final_idle", gnt4, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
